// File: rtl/photodiode_event_scheduler_pkg.sv
// Shared constants and the event record for the photodiode event scheduler.
// Build option PHOTODIODE_TIMESTAMP_EN adds a 16-bit millisecond stamp to each event.
package photodiode_sched_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_EVENT   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_MASK    = 2'd3;

  localparam int EV_VALID_BIT  = 31;
  localparam int EV_TYPE_BIT   = 8;
  localparam int EV_BEAM_LSB   = 0;
  localparam int EV_BEAM_W     = 3;
  localparam int EV_TS_LSB     = 12;
  localparam int EV_TS_W       = 16;

  localparam int ST_COUNT_LSB  = 0;
  localparam int ST_COUNT_W    = 5;
  localparam int ST_OVF_BIT    = 8;
  localparam int ST_STABLE_LSB = 16;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_OVF_CLR  = 2;

  typedef struct packed {
`ifdef PHOTODIODE_TIMESTAMP_EN
    logic [EV_TS_W-1:0]   ts;
`endif
    logic                 note_on;
    logic [EV_BEAM_W-1:0] beam;
  } event_t;

  function automatic logic [31:0] pack_event(input event_t ev);
    logic [31:0] word;
    word = '0;
    word[EV_VALID_BIT] = 1'b1;
    word[EV_TYPE_BIT] = ev.note_on;
    word[EV_BEAM_LSB +: EV_BEAM_W] = ev.beam;
`ifdef PHOTODIODE_TIMESTAMP_EN
    word[EV_TS_LSB +: EV_TS_W] = ev.ts;
`endif
    return word;
  endfunction

endpackage

// File: rtl/photodiode_event_scheduler_if.sv
// Avalon-MM register port between the HPS lightweight bridge and the scheduler.
interface photodiode_event_scheduler_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/photodiode_event_scheduler_debounce.sv
// Per-beam 2-flop synchroniser and debouncer; reports a one-cycle edge when a new level is accepted.
module beam_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_beam,
  output logic o_stable,
  output logic o_edge_on,
  output logic o_edge_off
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_take;

  assign w_differ = (r_sync_p1 != r_stable);
  assign w_take   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
      r_stable  <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= i_beam;
      r_sync_p1 <= r_sync_p0;
      if (w_take) begin
        r_stable <= r_sync_p1;
        r_cnt    <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // A broken beam (level 0) starts a note.
  assign o_stable   = r_stable;
  assign o_edge_on  = w_take && !r_sync_p1;
  assign o_edge_off = w_take &&  r_sync_p1;
endmodule

// File: rtl/photodiode_event_scheduler.sv
// Laser-harp beam scheduler: debounced beam edges -> round-robin arbiter -> event FIFO -> Avalon-MM.
// Build option PHOTODIODE_TIMESTAMP_EN stamps each event with a free-running millisecond count.
module photodiode_event_scheduler
  import photodiode_sched_pkg::*;
#(
  parameter int NUM_BEAMS       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BEAMS-1:0]       beam_in,
  photodiode_event_scheduler_if.slave avs,
  output logic                       irq
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_BEAMS-1:0] w_stable, w_edge_on, w_edge_off, w_accept, w_grant_oh;
  logic [NUM_BEAMS-1:0] r_pend, r_type, r_mask;
  logic                 r_enable, r_irq_en, r_overflow, r_irq;
  logic [EV_BEAM_W-1:0] r_rr_ptr, w_grant_idx, w_scan;
  logic                 w_grant_vld, w_full, w_push, w_pop;
  logic                 w_ctrl_wr, w_mask_wr, w_pend_clr, w_ovf_set, w_ovf_clr;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [31:0]          r_rdata, w_rdata;
  event_t               r_mem [FIFO_DEPTH];
  event_t               w_push_ev;
  logic                 w_unused;

  for (genvar b = 0; b < NUM_BEAMS; b++) begin : g_beam
    beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk       (clk),
      .i_rst     (reset),
      .i_beam    (beam_in[b]),
      .o_stable  (w_stable[b]),
      .o_edge_on (w_edge_on[b]),
      .o_edge_off(w_edge_off[b])
    );
  end

  assign w_ctrl_wr  = avs.avs_write && (avs.avs_address == ADDR_CONTROL);
  assign w_mask_wr  = avs.avs_write && (avs.avs_address == ADDR_MASK);
  assign w_pend_clr = w_ctrl_wr && !avs.avs_writedata[CTRL_ENABLE];
  assign w_ovf_clr  = w_ctrl_wr &&  avs.avs_writedata[CTRL_OVF_CLR];
  assign w_accept   = (w_edge_on | w_edge_off) & r_mask & {NUM_BEAMS{r_enable}};
  assign w_unused   = &{1'b0, avs.avs_writedata};

  // An edge landing on a beam in its grant cycle re-arms it rather than counting as overflow.
  assign w_ovf_set  = !w_pend_clr && |(w_accept & r_pend & ~w_grant_oh);

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = avs.avs_read && (avs.avs_address == ADDR_EVENT) && (r_count != '0);
  assign w_push = w_grant_vld;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    if (!w_full) begin
      for (int i = 0; i < NUM_BEAMS; i++) begin
        w_scan = EV_BEAM_W'((int'(r_rr_ptr) + i) % NUM_BEAMS);
        if (!w_grant_vld && r_pend[w_scan]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_scan;
        end
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? (NUM_BEAMS'(1) << w_grant_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_type   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_pend_clr) begin
        r_pend <= '0;
      end else begin
        r_pend <= (r_pend & ~w_grant_oh) | w_accept;
        for (int b = 0; b < NUM_BEAMS; b++) begin
          if (w_accept[b]) r_type[b] <= w_edge_on[b];
        end
      end
      if (w_grant_vld) begin
        r_rr_ptr <= (w_grant_idx == EV_BEAM_W'(NUM_BEAMS - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

`ifdef PHOTODIODE_TIMESTAMP_EN
  localparam int DIV_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DIV_W-1:0]   r_ts_div;
  logic [EV_TS_W-1:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts_div <= '0;
      r_ts     <= '0;
    end else if (r_ts_div == DIV_W'(DEBOUNCE_CYCLES - 1)) begin
      r_ts_div <= '0;
      r_ts     <= r_ts + 1'b1;
    end else begin
      r_ts_div <= r_ts_div + 1'b1;
    end
  end
`endif

  always_comb begin
    w_push_ev         = '0;
    w_push_ev.note_on = r_type[w_grant_idx];
    w_push_ev.beam    = w_grant_idx;
`ifdef PHOTODIODE_TIMESTAMP_EN
    w_push_ev.ts      = r_ts;
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_mask     <= '1;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= avs.avs_writedata[CTRL_ENABLE];
        r_irq_en <= avs.avs_writedata[CTRL_IRQ_EN];
      end
      if (w_mask_wr) r_mask <= avs.avs_writedata[NUM_BEAMS-1:0];
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs.avs_address)
      ADDR_STATUS: begin
        w_rdata[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(r_count);
        w_rdata[ST_OVF_BIT]                  = r_overflow;
        w_rdata[ST_STABLE_LSB +: NUM_BEAMS]  = w_stable;
      end
      ADDR_EVENT: begin
        if (r_count != '0) w_rdata = pack_event(r_mem[r_rd_ptr]);
      end
      ADDR_CONTROL: begin
        w_rdata[CTRL_ENABLE] = r_enable;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      default: begin
        w_rdata[NUM_BEAMS-1:0] = r_mask;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (avs.avs_read) r_rdata <= w_rdata;
      r_irq <= r_irq_en && (r_count != '0);
    end
  end

  assign avs.avs_readdata = r_rdata;
  assign irq              = r_irq;
endmodule

// File: tb/tb_photodiode_event_scheduler.sv
// Bench for photodiode_event_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_photodiode_event_scheduler;
  localparam int NB = 8;
  localparam int DC = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] beam_in = '1;
  logic          irq;

  photodiode_event_scheduler_if u_if();

  photodiode_event_scheduler #(
    .NUM_BEAMS(NB), .DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .beam_in(beam_in), .avs(u_if), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: levels seen after a 2-cycle synchroniser, run-length debounce,
  // pending bits per beam, and the FIFO as a queue of finished event words.
  logic [NB-1:0] m_s1, m_s2, m_stable, m_pend, m_type, m_mask;
  int            m_run [NB];
  int            m_rr;
  logic          m_en, m_irqen, m_ovf, m_irq, m_rd_chk;
  logic [31:0]   m_rdata;
  logic [31:0]   m_q [$];

  always @(posedge clk or posedge reset) begin : model
    int g, n, idx;
    logic [NB-1:0] e_on, e_off, p_old, mask_old;
    logic en_old, irqen_old, acc, ovf_set, ovf_clr, pclr;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_pend = '0; m_type = '0; m_mask = '1;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
      m_rr = 0; m_en = 0; m_irqen = 0; m_ovf = 0; m_irq = 0; m_rd_chk = 0; m_rdata = '0;
      m_q.delete();
    end else begin
      n = m_q.size(); en_old = m_en; irqen_old = m_irqen; mask_old = m_mask; p_old = m_pend;
      g = -1;
      if (n < FD) begin
        for (int i = 0; i < NB; i++) begin
          idx = (m_rr + i) % NB;
          if (g < 0 && p_old[idx]) g = idx;
        end
      end
      m_rd_chk = u_if.avs_read;
      if (u_if.avs_read) begin
        case (u_if.avs_address)
          2'd0: m_rdata = {8'h00, m_stable, 7'h00, m_ovf, 3'h0, 5'(n)};
          2'd1: m_rdata = (n > 0) ? m_q.pop_front() : 32'h0;
          2'd2: m_rdata = {30'd0, m_irqen, m_en};
          default: m_rdata = {24'd0, m_mask};
        endcase
      end
      if (g >= 0) begin
        m_q.push_back(32'h8000_0000 | (32'(m_type[g]) << 8) | 32'(g));
        m_rr = (g + 1) % NB;
      end
      for (int b = 0; b < NB; b++) begin
        e_on[b] = 1'b0; e_off[b] = 1'b0;
        if (m_s2[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_stable[b] = m_s2[b];
            m_run[b] = 0;
            if (m_s2[b]) e_off[b] = 1'b1; else e_on[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      pclr    = u_if.avs_write && u_if.avs_address == 2'd2 && !u_if.avs_writedata[0];
      ovf_clr = u_if.avs_write && u_if.avs_address == 2'd2 &&  u_if.avs_writedata[2];
      ovf_set = 1'b0;
      for (int b = 0; b < NB; b++) begin
        acc = (e_on[b] | e_off[b]) && en_old && mask_old[b];
        if (pclr) m_pend[b] = 1'b0;
        else if (acc) begin
          if (p_old[b] && g != b) ovf_set = 1'b1;
          m_pend[b] = 1'b1;
          m_type[b] = e_on[b];
        end else if (g == b) m_pend[b] = 1'b0;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (u_if.avs_write && u_if.avs_address == 2'd2) begin
        m_en = u_if.avs_writedata[0]; m_irqen = u_if.avs_writedata[1];
      end
      if (u_if.avs_write && u_if.avs_address == 2'd3) m_mask = u_if.avs_writedata[NB-1:0];
      m_irq = irqen_old && (n != 0);
      m_s2 = m_s1; m_s1 = beam_in;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check_eq("irq_model", {31'd0, irq}, {31'd0, m_irq});
      if (m_rd_chk) check_eq("rdata_model", u_if.avs_readdata, m_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    u_if.avs_address = a; u_if.avs_read = 1'b1;
    @(negedge clk);
    u_if.avs_read = 1'b0;
    d = u_if.avs_readdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    u_if.avs_address = a; u_if.avs_writedata = wd; u_if.avs_write = 1'b1;
    @(negedge clk);
    u_if.avs_write = 1'b0;
  endtask

  task automatic set_beams(input logic [NB-1:0] v);
    @(negedge clk);
    beam_in = v;
  endtask

  task automatic drain();
    logic [31:0] d;
    for (int k = 0; k < 12; k++) begin
      bus_rd(2'd1, d);
      if (d == 32'h0) break;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    idle(2);
    check_eq("rst_rdata", u_if.avs_readdata, 32'h0);
    check_eq("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] wd;
    int k;
    u_if.avs_address = '0; u_if.avs_read = 1'b0; u_if.avs_write = 1'b0; u_if.avs_writedata = '0;
    idle(3);
    check_eq("rst_rdata", u_if.avs_readdata, 32'h0);
    check_eq("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    bus_rd(2'd0, d); check_eq("rst_status", d, 32'h00FF_0000);
    bus_rd(2'd3, d); check_eq("rst_mask", d, 32'h0000_00FF);
    bus_rd(2'd2, d); check_eq("rst_control", d, 32'h0);

    // Single break on beam 3, then its restore
    bus_wr(2'd2, 32'h1);
    set_beams(8'hF7); idle(12);
    bus_rd(2'd0, d); check_eq("t1_status", d, 32'h00F7_0001);
    bus_rd(2'd1, d); check_eq("t1_event", d, 32'h8000_0103);
    bus_rd(2'd1, d); check_eq("t1_empty", d, 32'h0);
    set_beams(8'hFF); idle(12);
    bus_rd(2'd1, d); check_eq("t1_off", d, 32'h8000_0003);

    // Short glitch on beam 5
    set_beams(8'hDF); idle(1); set_beams(8'hFF); idle(12);
    bus_rd(2'd0, d); check_eq("t2_status", d, 32'h00FF_0000);

    // Simultaneous breaks on 0, 2, 6 from rr_ptr 0
    pulse_reset();
    bus_wr(2'd2, 32'h1);
    set_beams(8'hBA); idle(12);
    bus_rd(2'd1, d); check_eq("t3_ev0", d, 32'h8000_0100);
    bus_rd(2'd1, d); check_eq("t3_ev2", d, 32'h8000_0102);
    bus_rd(2'd1, d); check_eq("t3_ev6", d, 32'h8000_0106);
    set_beams(8'hB8); idle(12);
    bus_rd(2'd1, d); check_eq("t3_wrap", d, 32'h8000_0101);
    set_beams(8'hFF); idle(12); drain();

    // Six events into a four-deep FIFO
    set_beams(8'hC0); idle(15);
    bus_rd(2'd0, d); check_eq("t4_full", d, 32'h00C0_0004);
    bus_rd(2'd1, d); bus_rd(2'd1, d); idle(4);
    bus_rd(2'd0, d); check_eq("t4_refill", d, 32'h00C0_0004);
    drain();
    bus_rd(2'd0, d); check_eq("t4_final", d, 32'h00C0_0000);
    set_beams(8'hFF); idle(15); drain();

    // Beam 4 breaks and restores while stuck pending behind a full FIFO
    set_beams(8'hF0); idle(15);
    set_beams(8'hE0); idle(12);
    set_beams(8'hF0); idle(12);
    bus_rd(2'd0, d); check_eq("t5_status", d, 32'h00F0_0104);
    for (int i = 0; i < 4; i++) bus_rd(2'd1, d);
    bus_rd(2'd1, d); check_eq("t5_type_off", d, 32'h8000_0004);
    bus_wr(2'd2, 32'h7);
    bus_rd(2'd0, d); check_eq("t5_ovf_clr", d, 32'h00F0_0000);
    set_beams(8'hFF); idle(12); drain();

    // Interrupt follows FIFO occupancy; reset mid-debounce
    bus_wr(2'd2, 32'h3);
    set_beams(8'h7F);
    k = 0;
    while (!irq && k < 30) begin @(negedge clk); k++; end
    check_eq("t6_irq_rise", {31'd0, irq}, 32'h1);
    bus_rd(2'd1, d); check_eq("t6_event", d, 32'h8000_0107);
    idle(2);
    check_eq("t6_irq_fall", {31'd0, irq}, 32'h0);
    set_beams(8'h7B); idle(2);
    pulse_reset();
    idle(20);
    bus_rd(2'd0, d); check_eq("t6_post_rst", d, 32'h007B_0000);
    bus_rd(2'd1, d); check_eq("t6_no_event", d, 32'h0);
    set_beams(8'hFF); idle(12);

    // Random traffic
    bus_wr(2'd2, 32'h3);
    bus_wr(2'd3, 32'($urandom_range(0, 255)) | 32'h5A);
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          set_beams(beam_in ^ (NB'(1) << $urandom_range(0, NB - 1)));
          idle($urandom_range(0, 8));
        end
        4, 5, 6: bus_rd(2'($urandom_range(0, 3)), d);
        7: begin
          wd = 32'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) wd = wd | 32'h1;
          bus_wr(2'd2, wd);
        end
        8: bus_wr(2'd3, $urandom);
        default: idle($urandom_range(1, 10));
      endcase
    end
    bus_wr(2'd2, 32'h3);
    set_beams(8'hFF); idle(20); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
